lector_contadores: RTL and testbench

- Downstream read sequencer for the pop-counter block (contadores).
- On a start request it drives the counter's req/idx read port and sweeps idx 0..NUM_CNT-1. It captures each returned count on valid into a result bank, then pulses done.
- A per-index timeout flags non-responding indices, so a sweep never hangs.
- Sits between the counter block and the test/report logic that checks packet totals per output FIFO.

---
 rtl/lector_pkg.sv | 17 +
 rtl/timeout_cnt.sv | 29 ++
 rtl/lector_contadores.sv | 102 ++++++++++
 tb/tb_lector_contadores.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/lector_pkg.sv
// Shared definitions for the counter read sequencer.
// State encoding and default sizes shared with the counter block.
package lector_pkg;

  localparam int NUM_CNT_D = 5;
  localparam int DATA_W_D  = 5;
  localparam int IDX_W_D   = 3;
  localparam int TIMEOUT_D = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/timeout_cnt.sv
// Per-index watchdog: down-counter with load/enable/expired.
// It stops at zero, so expired stays high until the next load.
module timeout_cnt #(
  parameter int W = 4
) (
  input  logic         CLK,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         expired
);

  logic [W-1:0] cnt;

  // Load on entry to a new index, count down while waiting.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/lector_contadores.sv
// Read sequencer: sweeps counter idx 0..NUM_CNT-1 into a bank.
// Each index gets one settle cycle, then waits for valid or timeout.
module lector_contadores
  import lector_pkg::*;
#(
  parameter int NUM_CNT = NUM_CNT_D,
  parameter int DATA_W  = DATA_W_D,
  parameter int IDX_W   = IDX_W_D,
  parameter int TIMEOUT = TIMEOUT_D
) (
  input  logic                      CLK,
  input  logic                      reset,
  input  logic                      start,
  output logic                      req,
  output logic [IDX_W-1:0]          idx,
  input  logic [DATA_W-1:0]         data,
  input  logic                      valid,
  output logic [NUM_CNT*DATA_W-1:0] cnt_out,
  output logic [NUM_CNT-1:0]        err_mask,
  output logic                      busy,
  output logic                      done
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TLOAD = TW'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_CNT - 1);

  state_t state;
  logic   t_load;
  logic   t_en;
  logic   t_exp;

  assign t_load = (state == SETTLE);
  assign t_en   = (state == CAPTURE);

  timeout_cnt #(
    .W(TW)
  ) u_tmo (
    .CLK     (CLK),
    .reset   (reset),
    .load    (t_load),
    .load_val(TLOAD),
    .en      (t_en),
    .expired (t_exp)
  );

  // Sweep FSM with registered handshake and result outputs.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      req      <= 1'b0;
      idx      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      cnt_out  <= '0;
      err_mask <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            cnt_out  <= '0;
            err_mask <= '0;
            idx      <= '0;
            req      <= 1'b1;
            busy     <= 1'b1;
            state    <= SETTLE;
          end
        end
        SETTLE: begin
          state <= CAPTURE;
        end
        CAPTURE: begin
          if (valid || t_exp) begin
            if (valid) begin
              cnt_out[int'(idx)*DATA_W +: DATA_W] <= data;
            end else begin
              err_mask[idx] <= 1'b1;
            end
            if (idx == LAST) begin
              idx   <= '0;
              req   <= 1'b0;
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              idx   <= idx + 1'b1;
              state <= SETTLE;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lector_contadores.sv
// Bench for lector_contadores with a behavioural counter model.
// Directed scenarios first, then randomized sweeps.
module tb_lector_contadores;

  localparam int N  = 5;
  localparam int DW = 5;
  localparam int IW = 3;
  localparam int TO = 8;

  logic          CLK;
  logic          reset;
  logic          start;
  logic          req;
  logic [IW-1:0] idx;
  logic [DW-1:0] data;
  logic          valid;
  logic [N*DW-1:0] cnt_out;
  logic [N-1:0]  err_mask;
  logic          busy;
  logic          done;

  int total = 0;
  int bad   = 0;

  int cnt_m [N];
  int lat_m [N];
  bit stale = 0;
  int age   = 0;
  logic          m_req = 0;
  logic [IW-1:0] m_idx = '0;

  lector_contadores #(
    .NUM_CNT(N),
    .DATA_W (DW),
    .IDX_W  (IW),
    .TIMEOUT(TO)
  ) dut (
    .CLK     (CLK),
    .reset   (reset),
    .start   (start),
    .req     (req),
    .idx     (idx),
    .data    (data),
    .valid   (valid),
    .cnt_out (cnt_out),
    .err_mask(err_mask),
    .busy    (busy),
    .done    (done)
  );

  initial CLK = 0;
  always #5 CLK = ~CLK;

  // Counter model: registered data, valid after lat_m edges of req.
  always @(posedge CLK) begin
    if (req) begin
      if (m_req && (idx == m_idx)) age = age + 1;
      else age = 1;
    end else begin
      age = 0;
    end
    m_req = req;
    m_idx = idx;
    if (int'(idx) < N) begin
      data  <= DW'(cnt_m[idx]);
      valid <= stale ||
        (req && lat_m[idx] != 0 && age >= lat_m[idx]);
    end else begin
      data  <= '0;
      valid <= stale;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic set_all(input int l);
    for (int i = 0; i < N; i++) lat_m[i] = l;
  endtask

  task automatic sweep(input bit repulse);
    int c;
    int exp_done;
    int done_at;
    int ndone;
    logic [N*DW-1:0] ecnt;
    logic [N-1:0]    eerr;
    exp_done = 1;
    ecnt = '0;
    eerr = '0;
    for (int i = 0; i < N; i++) begin
      if (stale || (lat_m[i] >= 1 && lat_m[i] <= TO)) begin
        c = stale ? 1 : lat_m[i];
        ecnt[i*DW +: DW] = DW'(cnt_m[i]);
      end else begin
        c = TO;
        eerr[i] = 1'b1;
      end
      exp_done += 1 + c;
    end
    done_at = 0;
    ndone = 0;
    @(negedge CLK);
    start = 1;
    @(posedge CLK);
    for (int cyc = 1; cyc <= exp_done + 15; cyc++) begin
      @(negedge CLK);
      start = repulse && (cyc == 4 || cyc == exp_done);
      chk("req", 32'(req), 32'(cyc < exp_done));
      chk("busy", 32'(busy), 32'(cyc < exp_done));
      if (done) begin
        ndone++;
        done_at = cyc;
      end
    end
    start = 0;
    chk("ndone", ndone, 1);
    chk("done_cycle", done_at, exp_done);
    chk("cnt_out", 32'(cnt_out), 32'(ecnt));
    chk("err_mask", 32'(err_mask), 32'(eerr));
    chk("idx_idle", 32'(idx), 0);
  endtask

  initial begin
    logic [N*DW-1:0] gold;
    reset = 0;
    start = 0;
    valid = 0;
    data  = '0;
    cnt_m = '{3, 7, 1, 31, 0};
    set_all(1);
    repeat (3) @(negedge CLK);
    chk("rst_req", 32'(req), 0);
    chk("rst_idx", 32'(idx), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_cnt", 32'(cnt_out), 0);
    chk("rst_err", 32'(err_mask), 0);
    reset = 1;
    repeat (2) @(negedge CLK);

    sweep(0);
    gold = {5'd0, 5'd31, 5'd1, 5'd7, 5'd3};
    chk("bank_const", 32'(cnt_out), 32'(gold));

    lat_m[2] = 0;
    sweep(0);
    chk("err_const", 32'(err_mask), 32'b00100);

    set_all(1);
    cnt_m = '{9, 22, 5, 17, 30};
    stale = 1;
    sweep(0);
    stale = 0;

    sweep(1);

    @(negedge CLK);
    start = 1;
    @(posedge CLK);
    repeat (8) @(negedge CLK);
    start = 0;
    chk("mid_idx", 32'(idx), 3);
    chk("mid_busy", 32'(busy), 1);
    reset = 0;
    #1;
    chk("arst_req", 32'(req), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_cnt", 32'(cnt_out), 0);
    chk("arst_err", 32'(err_mask), 0);
    chk("arst_idx", 32'(idx), 0);
    @(negedge CLK);
    reset = 1;
    @(negedge CLK);
    sweep(0);

    lat_m[1] = TO;
    sweep(0);
    chk("edge_err1", 32'(err_mask[1]), 0);

    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < N; i++) begin
        cnt_m[i] = int'($urandom_range(0, 31));
        lat_m[i] = int'($urandom_range(0, TO + 2));
      end
      stale = ($urandom_range(0, 5) == 0);
      sweep(r[0]);
    end
    stale = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
